keypad_scanner: RTL and testbench

Upstream stage of the 4x4 matrix-keypad / 7-segment display path. Drives the keypad columns and samples the rows. Debounces both press and release. Delivers a 4-bit key code with a one-cycle valid strobe to the decoder/display stage. Codes 0x0-0xF feed the downstream hex 7-segment decoder directly.

---
 rtl/keypad_pkg.sv | 34 +++
 rtl/sync_2ff.sv | 29 ++
 rtl/keypad_scanner.sv | 146 ++++++++++++++
 tb/tb_keypad_scanner.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types, sizes and helpers for the 4x4 keypad scanner.
// The scanner top and its row synchronizer both import this package.
package keypad_pkg;

    localparam int KEY_ROWS   = 4;
    localparam int KEY_COLS   = 4;
    localparam int KEY_CODE_W = 4;
    localparam int ROW_IDX_W  = 2;
    localparam int COL_IDX_W  = 2;

    localparam logic [KEY_COLS-1:0] COL_RESET = 4'b1110;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Lowest-index low row wins when several rows are pulled down together.
    function automatic logic [ROW_IDX_W-1:0] row_lowest_zero(input logic [KEY_ROWS-1:0] rows);
        row_lowest_zero = '0;
        for (int i = KEY_ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) begin
                row_lowest_zero = ROW_IDX_W'(i);
            end
        end
    endfunction

    function automatic logic [KEY_COLS-1:0] col_next(input logic [KEY_COLS-1:0] col);
        col_next = {col[KEY_COLS-2:0], col[KEY_COLS-1]};
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// Resets to all-ones so idle (unpressed, active-low) rows are seen during reset.
module sync_2ff
    import keypad_pkg::*;
#(
    parameter int WIDTH = KEY_ROWS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sampling, press/release debounce,
// single-cycle key strobe with held flag for the 7-segment decoder stage.
//
// state    | meaning
// ---------+------------------------------------------------------------
// SCAN     | rotating columns, looking for any low row at the sample point
// DEBOUNCE | column frozen, counting samples that agree with the candidate
// HELD     | key accepted, column frozen, waiting for a released sample
// RELEASE  | column frozen, counting released samples before rescanning
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [KEY_ROWS-1:0]   row_signal,
    output logic [KEY_COLS-1:0]   col_signal,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_valid,
    output logic                  key_held
);

    logic [KEY_ROWS-1:0]   w_rows;
    logic                  w_sample;
    logic                  w_pressed;
    logic [ROW_IDX_W-1:0]  w_row_idx;
    logic [KEY_CODE_W-1:0] w_code;
    logic [3:0]            w_cnt_inc;

    logic [7:0]            r_dwell;
    state_t                r_state;
    logic [KEY_COLS-1:0]   r_col;
    logic [COL_IDX_W-1:0]  r_col_idx;
    logic [KEY_CODE_W-1:0] r_cand;
    logic [3:0]            r_cnt;
    logic [KEY_CODE_W-1:0] r_key_code;
    logic                  r_key_valid;
    logic                  r_key_held;

    sync_2ff #(
        .WIDTH(KEY_ROWS)
    ) u_row_sync (
        .clk (clk),
        .rst (rst),
        .i_d (row_signal),
        .o_q (w_rows)
    );

    // Dwell runs in every state; frozen states still need the sample cadence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dwell <= '0;
        end else if (w_sample) begin
            r_dwell <= '0;
        end else begin
            r_dwell <= r_dwell + 8'd1;
        end
    end

    assign w_sample  = (r_dwell == 8'(SCAN_DIV - 1));
    assign w_pressed = (w_rows != '1);
    assign w_row_idx = row_lowest_zero(w_rows);
    assign w_code    = {w_row_idx, r_col_idx};
    assign w_cnt_inc = r_cnt + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= SCAN;
            r_col       <= COL_RESET;
            r_col_idx   <= '0;
            r_cand      <= '0;
            r_cnt       <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (w_sample) begin
                case (r_state)
                    SCAN: begin
                        if (w_pressed) begin
                            r_cand  <= w_code;
                            r_cnt   <= 4'd1;
                            r_state <= DEBOUNCE;
                        end else begin
                            r_col     <= col_next(r_col);
                            r_col_idx <= r_col_idx + 2'd1;
                        end
                    end
                    DEBOUNCE: begin
                        if (w_pressed && (w_code == r_cand)) begin
                            if (w_cnt_inc == 4'(DEBOUNCE_CNT)) begin
                                r_key_code  <= r_cand;
                                r_key_valid <= 1'b1;
                                r_key_held  <= 1'b1;
                                r_cnt       <= '0;
                                r_state     <= HELD;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else begin
                            // Bounce or a different key: drop the candidate and move on.
                            r_cnt     <= '0;
                            r_state   <= SCAN;
                            r_col     <= col_next(r_col);
                            r_col_idx <= r_col_idx + 2'd1;
                        end
                    end
                    HELD: begin
                        if (!w_pressed) begin
                            r_cnt   <= 4'd1;
                            r_state <= RELEASE;
                        end
                    end
                    RELEASE: begin
                        if (!w_pressed) begin
                            if (w_cnt_inc == 4'(DEBOUNCE_CNT)) begin
                                r_key_held <= 1'b0;
                                r_cnt      <= '0;
                                r_state    <= SCAN;
                                r_col      <= col_next(r_col);
                                r_col_idx  <= r_col_idx + 2'd1;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else begin
                            r_cnt   <= '0;
                            r_state <= HELD;
                        end
                    end
                    default: begin
                        r_state <= SCAN;
                    end
                endcase
            end
        end
    end

    assign col_signal = r_col;
    assign key_code   = r_key_code;
    assign key_valid  = r_key_valid;
    assign key_held   = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_signal;
    logic [3:0] col_signal;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [3:0][3:0] keys;   // keys[row][col]

    int checks   = 0;
    int failures = 0;
    int vcnt     = 0;
    int dbl      = 0;
    int bad_hold = 0;
    logic [3:0] last_code = 4'h0;
    logic       prev_valid = 1'b0;

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .row_signal (row_signal),
        .col_signal (col_signal),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_held   (key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_signal = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r][c] && !col_signal[c]) row_signal[r] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (key_valid) begin
            vcnt = vcnt + 1;
            last_code = key_code;
            if (prev_valid) dbl = dbl + 1;
            if (!key_held) bad_hold = bad_hold + 1;
        end
        prev_valid = key_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        keys = '0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_held(input logic level, input int bound, output int n);
        n = 0;
        while ((key_held !== level) && (n < bound)) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        keys = '0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (col_signal !== 4'b1110) begin failures++; $display("FAIL reset_col got=%b exp=%b", col_signal, 4'b1110); end
        checks++; if (key_code !== 4'h0) begin failures++; $display("FAIL reset_code got=%h exp=0", key_code); end
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL reset_held got=%b exp=0", key_held); end
    endtask

    task automatic test_idle();
        int errs;
        int v0;
        logic [3:0] one;
        logic [3:0] expcol;
        errs = 0;
        one  = 4'b0001;
        keys = '0;
        @(negedge clk);
        rst = 1'b0;
        v0 = vcnt;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            expcol = ~(one << ((k / SCAN_DIV) % 4));
            if (col_signal !== expcol) begin
                if (errs == 0) $display("FAIL idle_walk cycle=%0d got=%b exp=%b", k, col_signal, expcol);
                errs++;
            end
        end
        checks++; if (errs != 0) begin failures++; $display("FAIL idle_walk_total got=%0d bad cycles exp=0", errs); end
        checks++; if (vcnt - v0 != 0) begin failures++; $display("FAIL idle_valid got=%0d pulses exp=0", vcnt - v0); end
    endtask

    task automatic test_bounce();
        int n;
        int v0;
        int changes;
        logic [3:0] prev;
        do_reset();
        keys[3][3] = 1'b1;
        n = 0;
        while ((col_signal !== 4'b0111) && (n < 40)) begin
            @(negedge clk);
            n++;
        end
        checks++; if (col_signal !== 4'b0111) begin failures++; $display("FAIL bounce_col3 got=%b exp=0111", col_signal); end
        v0 = vcnt;
        repeat (2 * SCAN_DIV) @(negedge clk);
        keys = '0;
        changes = 0;
        prev = col_signal;
        repeat (40) begin
            @(negedge clk);
            if (col_signal !== prev) changes++;
            prev = col_signal;
        end
        checks++; if (vcnt - v0 != 0) begin failures++; $display("FAIL bounce_valid got=%0d pulses exp=0", vcnt - v0); end
        checks++; if (key_code !== 4'h0) begin failures++; $display("FAIL bounce_code got=%h exp=0", key_code); end
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL bounce_held got=%b exp=0", key_held); end
        checks++; if (changes < 4) begin failures++; $display("FAIL bounce_rotate got=%0d changes exp>=4", changes); end
    endtask

    task automatic test_press();
        int n;
        int v0;
        int changes;
        logic [3:0] prev;
        keys = '0;
        keys[1][2] = 1'b1;
        v0 = vcnt;
        repeat (200) @(negedge clk);
        checks++; if (vcnt - v0 != 1) begin failures++; $display("FAIL press_pulses got=%0d exp=1", vcnt - v0); end
        checks++; if (key_code !== 4'd6) begin failures++; $display("FAIL press_code got=%h exp=6", key_code); end
        checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL press_held got=%b exp=1", key_held); end
        checks++; if (col_signal !== 4'b1011) begin failures++; $display("FAIL press_frozen got=%b exp=1011", col_signal); end
        keys = '0;
        wait_held(1'b0, 40, n);
        checks++;
        if ((key_held !== 1'b0) || (n < 3 + SCAN_DIV * (DEBOUNCE_CNT - 1)) || (n > 2 + SCAN_DIV * DEBOUNCE_CNT)) begin
            failures++;
            $display("FAIL release_latency got=%0d cycles held=%b exp=%0d..%0d held=0", n, key_held,
                     3 + SCAN_DIV * (DEBOUNCE_CNT - 1), 2 + SCAN_DIV * DEBOUNCE_CNT);
        end
        changes = 0;
        prev = col_signal;
        repeat (20) begin
            @(negedge clk);
            if (col_signal !== prev) changes++;
            prev = col_signal;
        end
        checks++; if (changes < 4) begin failures++; $display("FAIL press_rescan got=%0d changes exp>=4", changes); end
    endtask

    task automatic test_simultaneous();
        int n;
        int v0;
        keys = '0;
        keys[0][1] = 1'b1;
        keys[3][1] = 1'b1;
        v0 = vcnt;
        wait_held(1'b1, 100, n);
        repeat (50) @(negedge clk);
        checks++; if (vcnt - v0 != 1) begin failures++; $display("FAIL multi_pulses got=%0d exp=1", vcnt - v0); end
        checks++; if (key_code !== 4'd1) begin failures++; $display("FAIL multi_code got=%h exp=1", key_code); end
        keys = '0;
        wait_held(1'b0, 40, n);
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL multi_release held=%b exp=0", key_held); end
        keys[2][0] = 1'b1;
        v0 = vcnt;
        wait_held(1'b1, 100, n);
        @(negedge clk);
        checks++; if (key_code !== 4'd8) begin failures++; $display("FAIL single_code got=%h exp=8", key_code); end
        checks++; if ((vcnt - v0 != 1) || (last_code !== 4'd8)) begin failures++; $display("FAIL single_strobe pulses=%0d code=%h exp=1 8", vcnt - v0, last_code); end
        keys = '0;
        wait_held(1'b0, 40, n);
    endtask

    task automatic test_release_bounce();
        int n;
        int v0;
        int low_seen;
        keys = '0;
        keys[0][0] = 1'b1;
        v0 = vcnt;
        n = 0;
        while ((vcnt == v0) && (n < 100)) begin
            @(negedge clk);
            n++;
        end
        checks++; if (vcnt - v0 != 1) begin failures++; $display("FAIL rbounce_accept got=%0d pulses exp=1", vcnt - v0); end
        repeat (2) @(negedge clk);
        keys = '0;
        repeat (SCAN_DIV) @(negedge clk);
        keys[0][0] = 1'b1;
        low_seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (key_held !== 1'b1) low_seen++;
        end
        checks++; if (low_seen != 0) begin failures++; $display("FAIL rbounce_held got=%0d low cycles exp=0", low_seen); end
        checks++; if (vcnt - v0 != 1) begin failures++; $display("FAIL rbounce_repeat got=%0d pulses exp=1", vcnt - v0); end
        keys = '0;
        wait_held(1'b0, 40, n);
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL rbounce_clean held=%b exp=0", key_held); end
    endtask

    task automatic test_reset_mid_held();
        int n;
        int v0;
        keys = '0;
        keys[2][3] = 1'b1;
        wait_held(1'b1, 100, n);
        checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL midrst_pre held=%b exp=1", key_held); end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (col_signal !== 4'b1110) begin failures++; $display("FAIL midrst_col got=%b exp=1110", col_signal); end
        checks++; if (key_code !== 4'h0) begin failures++; $display("FAIL midrst_code got=%h exp=0", key_code); end
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", key_valid); end
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL midrst_held got=%b exp=0", key_held); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        v0 = vcnt;
        n = 0;
        while ((vcnt == v0) && (n < 100)) begin
            @(negedge clk);
            n++;
        end
        checks++; if ((vcnt - v0 != 1) || (last_code !== 4'd11)) begin failures++; $display("FAIL midrst_new pulses=%0d code=%h exp=1 b", vcnt - v0, last_code); end
        checks++; if (key_code !== 4'd11) begin failures++; $display("FAIL midrst_code_out got=%h exp=b", key_code); end
        keys = '0;
        wait_held(1'b0, 40, n);
    endtask

    task automatic test_strobe_shape();
        checks++; if (dbl != 0) begin failures++; $display("FAIL strobe_width got=%0d long pulses exp=0", dbl); end
        checks++; if (bad_hold != 0) begin failures++; $display("FAIL strobe_held got=%0d strobes without held exp=0", bad_hold); end
    endtask

    initial begin
        keys = '0;
        test_reset();
        test_idle();
        test_bounce();
        test_press();
        test_simultaneous();
        test_release_bounce();
        test_reset_mid_held();
        test_strobe_shape();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
